pulse_stretcher: RTL and testbench

- Converts single-cycle pulses (from the debounce/single-pulse front end) back into visible, fixed-width level pulses for LEDs, buzzer and 7-seg blink logic.
- Queue mode: every input pulse is replayed as a separate stretched pulse with a gap between pulses. Excess pulses are counted and saturate.
- Retrigger mode: the output stays high for HOLD_CYCLES after the most recent pulse.
- Sits between single-pulse generators and slow display/indicator logic on the same clock.

---
 rtl/pulse_stretcher.sv | 123 ++++++++++++
 tb/tb_pulse_stretcher.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into fixed-width level pulses (queue or retrigger mode).
// Ports: clock, reset_n, sp_in, retrigger -> hold_out, busy, pending[PEND_W], overflow.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sp_in,
  input  logic              retrigger,
  output logic              hold_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CMAX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              hold_q, busy_q, ovf_q, ovf_d;
  logic              inc, dec;

  // cnt_q counts down the remaining cycles of the current phase;
  // a phase ends when it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sp_in || pend_q != '0) begin
          state_d = HIGH;
          cnt_d   = HOLD_LD;
          // a live pulse is served directly, the queue waits
          dec     = !sp_in;
        end
      end
      HIGH: begin
        inc = sp_in && !retrigger;
        if (sp_in && retrigger) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        inc = sp_in;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (sp_in || pend_q != '0) begin
          // a pulse in the last gap cycle is queued and
          // consumed at once, netting to no change
          state_d = HIGH;
          cnt_d   = HOLD_LD;
          dec     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    unique case (1'b1)
      (inc && !dec): begin
        if (pend_q == MAX_P) ovf_d  = 1'b1;
        else                 pend_d = pend_q + 1'b1;
      end
      (dec && !inc): pend_d = pend_q - 1'b1;
      default:       pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hold_q  <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE) || (pend_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign hold_out = hold_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a phase-countdown model
// queues per-cycle expectations, a monitor compares them.
module tb_pulse_stretcher;
  localparam int HOLD = 8;
  localparam int GAPC = 2;
  localparam int MAXP = 7;
  localparam int PW   = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sp_in = 1'b0;
  logic          retrigger = 1'b0;
  logic          hold_out, busy, overflow;
  logic [PW-1:0] pending;

  typedef struct packed {
    logic          h;
    logic          b;
    logic [PW-1:0] p;
    logic          o;
  } exp_t;

  exp_t q[$];
  exp_t e_m, a_m;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ovf_cnt = 0;
  int   m_hi = 0;
  int   m_gap = 0;
  int   m_pend = 0;
  bit   rt_r = 1'b0;

  pulse_stretcher #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .MAX_PENDING(MAXP),
    .PEND_W     (PW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sp_in    (sp_in),
    .retrigger(retrigger),
    .hold_out (hold_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    #1;
    if (overflow) ovf_cnt++;
    if (q.size() > 0) begin
      e_m = q.pop_front();
      a_m = '{h: hold_out, b: busy, p: pending, o: overflow};
      tests++;
      if (a_m !== e_m) begin
        fails++;
        $display("FAIL outputs cyc=%0d got h=%0b b=%0b p=%0d o=%0b want h=%0b b=%0b p=%0d o=%0b",
                 cyc, a_m.h, a_m.b, a_m.p, a_m.o, e_m.h, e_m.b, e_m.p, e_m.o);
      end
    end
  end

  // Model: m_hi / m_gap are cycles left in the high / gap phase,
  // m_pend is the number of requests still waiting to be replayed.
  task automatic drive(input bit sp, input bit rt);
    int   take, inc, nh, ng, tot;
    bit   ov;
    exp_t x;
    @(negedge clock);
    sp_in = sp;
    retrigger = rt;
    take = 0; inc = 0; nh = 0; ng = 0;
    if (m_hi > 0) begin
      inc = (sp && !rt) ? 1 : 0;
      if (sp && rt)       nh = HOLD;
      else if (m_hi == 1) ng = GAPC;
      else                nh = m_hi - 1;
    end else if (m_gap > 0) begin
      inc = sp ? 1 : 0;
      if (m_gap > 1) ng = m_gap - 1;
      else if (m_pend + inc > 0) begin
        nh = HOLD;
        take = 1;
      end
    end else if (sp) begin
      nh = HOLD;
    end else if (m_pend > 0) begin
      nh = HOLD;
      take = 1;
    end
    tot = m_pend + inc - take;
    ov = (tot > MAXP);
    if (ov) tot = MAXP;
    m_hi = nh; m_gap = ng; m_pend = tot;
    x.h = (nh > 0);
    x.b = (nh > 0) || (ng > 0) || (tot > 0);
    x.p = PW'(tot);
    x.o = ov;
    q.push_back(x);
  endtask

  task automatic idle(input int n, input bit rt);
    for (int i = 0; i < n; i++) drive(1'b0, rt);
  endtask

  task automatic async_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({hold_out, busy, pending, overflow} !== '0) begin
      fails++;
      $display("FAIL async_reset got h=%0b b=%0b p=%0d o=%0b want all 0",
               hold_out, busy, pending, overflow);
    end
    q.delete();
    m_hi = 0; m_gap = 0; m_pend = 0;
    sp_in = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({hold_out, busy, pending, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state got h=%0b b=%0b p=%0d o=%0b want all 0",
               hold_out, busy, pending, overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;

    idle(3, 0);
    drive(1, 0); idle(15, 0);
    repeat (3) drive(1, 0); idle(45, 0);
    drive(1, 1); idle(4, 1); drive(1, 1); idle(20, 1);

    ovf_cnt = 0;
    repeat (9) drive(1, 0);
    idle(90, 0);
    tests++;
    if (ovf_cnt != 1) begin
      fails++;
      $display("FAIL overflow_pulses got %0d want 1", ovf_cnt);
    end

    drive(1, 0); drive(1, 0); idle(2, 0);
    async_reset();
    idle(5, 0); drive(1, 0); idle(15, 0);

    drive(1, 1); idle(9, 1); drive(1, 1); idle(15, 1);

    for (int blk = 0; blk < 15; blk++) begin
      int pct;
      pct = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 25 : 8);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 3) rt_r = ~rt_r;
        if ($urandom_range(0, 999) < 4) async_reset();
        else drive($urandom_range(0, 99) < pct, rt_r);
      end
    end

    idle(120, 0);
    @(posedge clock);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
